// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath blocks (serializer, adders,
// deserializer) and the reference vectors their benches have in common.
package serial_pkg;

  localparam int SERIAL_W_DEFAULT = 16;

  typedef logic [$clog2(SERIAL_W_DEFAULT)-1:0] serial_cnt_t;

  // Operands and expected sum used by every serial-block bench: A + B = SUM.
  localparam logic [15:0] SERIAL_TV_A   = 16'h4DB4;
  localparam logic [15:0] SERIAL_TV_B   = 16'h1D62;
  localparam logic [15:0] SERIAL_TV_SUM = 16'h6B16;

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-W bit position counter for word-framed serial streams.
// restart marks the current bit as bit 0 of a new word, so the count moves
// straight to 1; inc advances by one and wraps after position W-1.
module serial_bit_counter #(
  parameter  int W  = 16,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          restart,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(W - 1));
  assign cnt  = cnt_q;

  // Next bit position: restart wins over a plain increment.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CW'(1);
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Assembles an LSB-first serial bit stream into W-bit words delivered on a
// valid/ready interface. A single output register lets the next word be
// collected while the previous one waits; only the final bit of a word can
// stall, and only while the output register is still occupied.
module serial_word_deserializer
  import serial_pkg::*;
#(
  parameter int W = SERIAL_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_first,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         frame_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          accept;
  logic          restart;
  logic          resync_err;
  logic          complete;

  logic [W-1:0]  sr_q;
  logic [W-1:0]  sr_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic [W-1:0]  out_data_q;
  logic [W-1:0]  out_data_d;
  logic          frame_err_q;
  logic          frame_err_d;

  // in_ready depends only on state and out_ready so the producer never sees
  // a combinational path from its own in_valid.
  assign in_ready   = !(cnt_last && out_valid_q && !out_ready);
  assign accept     = in_valid && in_ready;
  assign restart    = accept && in_first;
  // A resync in the middle of a word throws the partial word away.
  assign resync_err = restart && (cnt != '0);
  // A resync bit is always bit 0, so it can never also complete a word.
  assign complete   = accept && cnt_last && !in_first;

  serial_bit_counter #(
    .W (W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (accept),
    .restart (restart),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  // Shift each accepted bit in at the top; after W bits the first one sits in
  // bit 0. Stale bits left over from a resync are shifted out before use.
  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      sr_d = {in_bit, sr_q[W-1:1]};
    end
  end

  // Output register: a completing word overrides a same-edge consume.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = {in_bit, sr_q[W-1:1]};
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Framing error is a registered single-cycle pulse per discarding resync.
  always_comb begin
    frame_err_d = resync_err;
  end

  // State registers; reset drops any partial or pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (W = 16).
module tb_serial_word_deserializer;
  import serial_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic         in_first;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         frame_err;

  int checks;
  int errors;
  int stalls;
  int words;
  int ferrs;
  int cyc;

  serial_word_deserializer #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side monitors: consumed words, frame error pulses, cycle count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && out_valid && out_ready) words <= words + 1;
    if (!rst && frame_err) ferrs <= ferrs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit at a negedge and return at the negedge after it is taken.
  task automatic send_bit(input logic b, input logic f);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_first = f;
    #1;
    if (!in_ready) stalls++;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_bound", 32'(guard >= 100), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic mark_first);
    for (int i = 0; i < 16; i++) send_bit(w[i], mark_first && (i == 0));
  endtask

  int w0, f0, s0, t1, t2;
  logic [15:0] ffff_w;

  initial begin
    checks = 0; errors = 0; stalls = 0; words = 0; ferrs = 0; cyc = 0;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0; out_ready = 1'b1;
    ffff_w = 16'hFFFF;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a word
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("midrst_out_valid_hold", 32'(out_valid), 32'd0);
    rst = 1'b0;
    w0 = words; f0 = ferrs;
    send_word(SERIAL_TV_SUM, 1'b1);
    chk("midrst_word_valid", 32'(out_valid), 32'd1);
    chk("midrst_word_data", 32'(out_data), 32'(SERIAL_TV_SUM));
    @(negedge clk);
    chk("midrst_word_count", 32'(words - w0), 32'd1);
    chk("midrst_no_ferr", 32'(ferrs - f0), 32'd0);

    // Single word 0x6B16, one-cycle valid
    send_word(16'b0110_1011_0001_0110, 1'b1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h6B16);
    @(negedge clk);
    chk("single_valid_drop", 32'(out_valid), 32'd0);

    // Back-to-back words with no bubbles
    s0 = stalls; w0 = words;
    send_word(SERIAL_TV_A, 1'b1);
    t1 = cyc;
    chk("b2b_w1_valid", 32'(out_valid), 32'd1);
    chk("b2b_w1_data", 32'(out_data), 32'h4DB4);
    send_word(SERIAL_TV_B, 1'b1);
    t2 = cyc;
    chk("b2b_w2_valid", 32'(out_valid), 32'd1);
    chk("b2b_w2_data", 32'(out_data), 32'h1D62);
    chk("b2b_spacing", 32'(t2 - t1), 32'd16);
    chk("b2b_no_stall", 32'(stalls - s0), 32'd0);
    @(negedge clk);
    chk("b2b_word_count", 32'(words - w0), 32'd2);

    // Backpressure: word 1 held while word 2 streams in
    w0 = words;
    send_word(16'h6B16, 1'b1);
    out_ready = 1'b0;
    s0 = stalls;
    for (int i = 0; i < 15; i++) send_bit(ffff_w[i], i == 0);
    chk("bp_no_early_stall", 32'(stalls - s0), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", 32'(out_data), 32'h6B16);
    in_valid = 1'b1; in_bit = 1'b1; in_first = 1'b0;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    chk("bp_data_stable", 32'(out_data), 32'h6B16);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    // Consume of word 1 and completion of word 2 share this edge.
    @(negedge clk);
    in_valid = 1'b0;
    chk("simul_valid_kept", 32'(out_valid), 32'd1);
    chk("simul_data_new", 32'(out_data), 32'hFFFF);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_word_count", 32'(words - w0), 32'd2);

    // Resync after 7 bits of a partial word
    f0 = ferrs;
    for (int i = 0; i < 7; i++) send_bit(i[0], i == 0);
    send_bit(1'b1, 1'b1);
    chk("resync_ferr_pulse", 32'(frame_err), 32'd1);
    send_bit(1'b0, 1'b0);
    chk("resync_ferr_one_cycle", 32'(frame_err), 32'd0);
    for (int i = 2; i < 16; i++) send_bit(1'b0, 1'b0);
    chk("resync_valid", 32'(out_valid), 32'd1);
    chk("resync_data", 32'(out_data), 32'h0001);
    chk("resync_ferr_count", 32'(ferrs - f0), 32'd1);
    @(negedge clk);

    // Count-based framing with no in_first
    f0 = ferrs;
    send_word(16'hA5C3, 1'b0);
    chk("nofirst_data", 32'(out_data), 32'hA5C3);
    chk("nofirst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("nofirst_no_ferr", 32'(ferrs - f0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
